// File: rtl/neuron_pkg.sv
// Shared types and width helpers for the neuron layer blocks.
package neuron_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    NORM,
    DIVIDE,
    DONE
  } state_t;

  // Fixed-point 1.0 for a given number of fraction bits.
  function automatic longint unsigned one_of(input int frac_w);
    return 64'd1 << frac_w;
  endfunction

  function automatic int acc_width(input int n_inputs, input int data_w);
    return 2 * data_w + $clog2(n_inputs) + 1;
  endfunction

  // Counter width able to index 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/neuron_div_seq.sv
// Iterative unsigned restoring divider: one quotient bit per cycle, MSB first,
// exactly Q_W cycles after start. rem_init must be smaller than den.
module neuron_div_seq
  import neuron_pkg::*;
#(
  parameter int DEN_W = 33,
  parameter int Q_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DEN_W-1:0] rem_init,
  input  logic [DEN_W-1:0] den,
  output logic             done,
  output logic [Q_W-1:0]   quo
);

  localparam int CNT_W = cnt_width(Q_W);

  logic [DEN_W-1:0] rem_q;
  logic [DEN_W-1:0] den_q;
  logic [Q_W-1:0]   quo_q;
  logic [CNT_W-1:0] step_q;
  logic             run_q;

  logic [DEN_W:0]   shifted;
  logic             fits;
  logic [DEN_W-1:0] rem_next;

  assign shifted  = {rem_q, 1'b0};
  assign fits     = shifted >= {1'b0, den_q};
  assign rem_next = fits ? DEN_W'(shifted - {1'b0, den_q}) : DEN_W'(shifted);

  // done and quo are combinational so the caller can register the result on
  // the same edge that resolves the last quotient bit.
  assign done = run_q && (step_q == CNT_W'(Q_W - 1));
  assign quo  = Q_W'({quo_q, fits});

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create ordering-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      den_q  <= '0;
      quo_q  <= '0;
      step_q <= '0;
      run_q  <= 1'b0;
    end else if (start) begin
      rem_q  <= rem_init;
      den_q  <= den;
      quo_q  <= '0;
      step_q <= '0;
      run_q  <= 1'b1;
    end else if (run_q) begin
      rem_q  <= rem_next;
      quo_q  <= quo;
      step_q <= step_q + 1'b1;
      if (done) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/neuron_seq.sv
// Sequential MAC neuron with softsign-sigmoid activation.
// Define NEURON_SAT_EN to saturate z to DATA_W bits instead of wrapping.
module neuron_seq
  import neuron_pkg::*;
#(
  parameter int N_INPUTS = 4,
  parameter int DATA_W   = 32,
  parameter int FRAC_W   = 16,
  parameter int ACC_W    = acc_width(N_INPUTS, DATA_W)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic signed [DATA_W-1:0] bias,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_x,
  input  logic signed [DATA_W-1:0] in_w,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_val,
  output logic                     busy
);

  localparam int                CNT_W = cnt_width(N_INPUTS);
  localparam int                DEN_W = DATA_W + 1;
  localparam logic [DEN_W-1:0]  ONE   = DEN_W'(one_of(FRAC_W));

  state_t                   state, state_nx;
  logic signed [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]         cnt;
  logic                     sign;

  logic signed [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]          z;
  logic [DATA_W-1:0]          abs_z;
  logic                       div_done;
  logic [FRAC_W-1:0]          div_quo;
  logic [DEN_W-1:0]           half_sum;

  assign prod = in_x * in_w;

`ifdef NEURON_SAT_EN
  logic signed [ACC_W-1:0] acc_sh;
  logic                    pos_ovf, neg_ovf;

  assign acc_sh  = acc >>> FRAC_W;
  assign pos_ovf = !acc_sh[ACC_W-1] && (|acc_sh[ACC_W-2:DATA_W-1]);
  assign neg_ovf =  acc_sh[ACC_W-1] && !(&acc_sh[ACC_W-2:DATA_W-1]);
  assign z = pos_ovf ? {1'b0, {(DATA_W-1){1'b1}}} :
             neg_ovf ? {1'b1, {(DATA_W-1){1'b0}}} :
                       acc_sh[DATA_W-1:0];
`else
  assign z = acc[FRAC_W +: DATA_W];
`endif

  // Unsigned magnitude so that |-2^(DATA_W-1)| is still representable.
  assign abs_z    = z[DATA_W-1] ? -z : z;
  assign half_sum = sign ? (ONE - DEN_W'(div_quo)) : (ONE + DEN_W'(div_quo));

  neuron_div_seq #(
    .DEN_W (DEN_W),
    .Q_W   (FRAC_W)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (state == NORM),
    .rem_init ({1'b0, abs_z}),
    .den      (ONE + {1'b0, abs_z}),
    .done     (div_done),
    .quo      (div_quo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // NOTE: every output of this block gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    busy     = (state != IDLE);
    unique case (state)
      IDLE:   if (start) state_nx = ACCUM;
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && (cnt == CNT_W'(N_INPUTS - 1))) state_nx = NORM;
      end
      NORM:   state_nx = DIVIDE;
      DIVIDE: if (div_done) state_nx = DONE;
      DONE:   if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      cnt       <= '0;
      sign      <= 1'b0;
      out_val   <= '0;
      out_valid <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        acc <= ACC_W'(bias) <<< FRAC_W;
        cnt <= '0;
      end
      if (state == ACCUM && in_valid) begin
        acc <= acc + ACC_W'(prod);
        cnt <= cnt + 1'b1;
      end
      if (state == NORM) sign <= z[DATA_W-1];
      if (state == DIVIDE && div_done) begin
        out_val   <= DATA_W'(half_sum >> 1);
        out_valid <= 1'b1;
      end
      if (state == DONE && out_ready) out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_neuron_seq.sv
// Directed self-checking bench for neuron_seq at default parameters.
// Honours NEURON_SAT_EN when choosing the expected overflow result.
module tb_neuron_seq;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic signed [31:0] bias;
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] in_x;
  logic signed [31:0] in_w;
  logic               out_valid;
  logic               out_ready;
  logic [31:0]        out_val;
  logic               busy;

  int n_cmp = 0;
  int n_err = 0;

  neuron_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bias      (bias),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_w      (in_w),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_val   (out_val),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Wide-precision reference: exact accumulate, reduce z, integer divide.
  function automatic logic [31:0] ref_out(input logic signed [31:0] b,
                                          input logic [3:0][31:0] xs,
                                          input logic [3:0][31:0] ws);
    logic signed [127:0] acc, xv, wv, zw;
    logic signed [63:0]  z;
    logic [63:0]         a, q, r;
    acc = b;
    acc = acc <<< 16;
    for (int i = 0; i < 4; i++) begin
      xv  = $signed(xs[i]);
      wv  = $signed(ws[i]);
      acc = acc + xv * wv;
    end
    zw = acc >>> 16;
`ifdef NEURON_SAT_EN
    if (zw > 128'sh7FFFFFFF)       zw = 128'sh7FFFFFFF;
    else if (zw < -128'sh80000000) zw = -128'sh80000000;
`endif
    z = $signed(zw[31:0]);
    a = (z < 0) ? 64'(-z) : 64'(z);
    q = (a << 16) / (64'd65536 + a);
    r = (z < 0) ? (64'd65536 - q) >> 1 : (64'd65536 + q) >> 1;
    return r[31:0];
  endfunction

  // One full evaluation, aligned to negedges; lat counts cycles from start.
  task automatic run_eval(input logic signed [31:0] b,
                          input logic [3:0][31:0] xs,
                          input logic [3:0][31:0] ws,
                          input bit toggle, input int hold,
                          output logic [31:0] res, output int lat);
    int  i, guard;
    bit  phase, valid_now, acc_now;
    out_ready = (hold == 0);
    start = 1'b1;
    bias  = b;
    lat   = 0;
    @(negedge clk);
    start = 1'b0;
    lat++;
    check("in_ready_after_start", in_ready, 1);
    check("busy_in_accum", busy, 1);
    i = 0; guard = 0; phase = 1'b1;
    while (i < 4 && guard < 100) begin
      valid_now = !toggle || phase;
      phase     = !phase;
      in_valid  = valid_now;
      in_x      = valid_now ? xs[i] : 32'hDEADBEEF;
      in_w      = valid_now ? ws[i] : 32'h1234_5678;
      acc_now   = valid_now && in_ready;
      @(negedge clk);
      lat++; guard++;
      if (acc_now) i++;
    end
    in_valid = 1'b0;
    check("pairs_accepted", i, 4);
    guard = 0;
    while (!out_valid && guard < 100) begin
      @(negedge clk);
      lat++; guard++;
    end
    check("out_valid_rise", out_valid, 1);
    res = out_val;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("hold_out_val", out_val, res);
      check("hold_out_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid_after_hs", out_valid, 0);
    check("busy_after_hs", busy, 0);
    check("out_val_held", out_val, res);
  endtask

  logic [3:0][31:0] xs, ws;
  logic [31:0]      res;
  int               lat;

  initial begin
    rst_n = 1'b0; start = 1'b0; bias = '0; in_valid = 1'b0;
    in_x = '0; in_w = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_val", out_val, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // z = 0 -> 0.5; also pins the 22-cycle latency.
    xs = '0; ws = '0;
    run_eval(32'sd0, xs, ws, 1'b0, 0, res, lat);
    check("zero_out", res, 32768);
    check("zero_latency", lat, 22);

    // z = 1.0 from one product.
    xs = '0; xs[0] = 32'd65536;
    ws = '0; ws[0] = 32'd65536;
    run_eval(32'sd0, xs, ws, 1'b0, 0, res, lat);
    check("z1_out", res, 49152);

    // Bias-only cases: z = -1.0 and z = 3.0.
    xs = '0; ws = '0;
    run_eval(-32'sd65536, xs, ws, 1'b0, 0, res, lat);
    check("zneg1_out", res, 16384);
    run_eval(32'sd196608, xs, ws, 1'b0, 0, res, lat);
    check("z3_out", res, 57344);

    // Stalled input and back-pressured output; sum of products is 3.0.
    xs[0] = 32'd65536;   ws[0] = 32'd65536;
    xs[1] = 32'd131072;  ws[1] = 32'd65536;
    xs[2] = -32'sd65536; ws[2] = 32'd65536;
    xs[3] = 32'd32768;   ws[3] = 32'd131072;
    run_eval(32'sd0, xs, ws, 1'b1, 5, res, lat);
    check("toggle_out", res, 57344);

    // Reset in the middle of DIVIDE discards the evaluation.
    start = 1'b1; bias = '0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_x     = (i == 0) ? 32'sd65536 : 32'sd0;
      in_w     = 32'sd65536;
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    check("busy_before_rst", busy, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    xs = '0; xs[0] = 32'd65536;
    ws = '0; ws[0] = 32'd65536;
    run_eval(32'sd0, xs, ws, 1'b0, 0, res, lat);
    check("after_rst_out", res, 49152);

    // Overflowing accumulation: saturates or wraps depending on the build.
    for (int i = 0; i < 4; i++) begin
      xs[i] = 32'h7FFF0000;
      ws[i] = 32'h7FFF0000;
    end
    run_eval(32'sd0, xs, ws, 1'b0, 0, res, lat);
    check("ovf_model", res, ref_out(32'sd0, xs, ws));
`ifdef NEURON_SAT_EN
    check("ovf_const", res, 65535);
`else
    check("ovf_const", res, 58982);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/neuron_seq.md
# neuron_seq

Sequential, parametrised successor to the two-input combinational neuron. It accepts a bias, then streams N_INPUTS (x, w) pairs through a valid/ready handshake into a single shared multiplier-accumulator. It applies the softsign-sigmoid activation out = 0.5·(1 + z/(1+|z|)) in signed fixed point, using an iterative restoring divider. It sits between the layer weight/activation buffers and the next layer's input stream; one instance per neuron lane.

## Interface
- N_INPUTS, 4, number of (x, w) pairs per evaluation (≥1)
- DATA_W, 32, width of x, w, b, out (signed two's complement)
- FRAC_W, 16, fraction bits (one = 2^FRAC_W; default one = 65536)
- ACC_W, 2·DATA_W + $clog2(N_INPUTS) + 1, internal accumulator width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin evaluation; sampled only in IDLE
- bias  in  DATA_W  bias b, captured with accepted start
- in_valid  in  1  pair valid
- in_ready  out  1  pair accepted when in_valid & in_ready
- in_x  in  DATA_W  input activation
- in_w  in  DATA_W  weight
- out_valid  out  1  result valid, held until accepted
- out_ready  in  1  downstream accepts when out_valid & out_ready
- out_val  out  DATA_W  activation result, range [0, one]
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, ACCUM, NORM, DIVIDE, DONE.
- IDLE: start=1 → acc ← sign-extended bias << FRAC_W, cnt ← 0, go to ACCUM. start in any other state is ignored.
- ACCUM: in_ready=1. Each accepted pair: acc ← acc + in_x·in_w, full-precision 2·DATA_W signed product, cnt++. On acceptance with cnt = N_INPUTS−1 → NORM. in_valid low stalls with no state change.
- NORM: z ← acc >>> FRAC_W, reduced to DATA_W (see Configuration). sign ← z[DATA_W−1], abs_z ← |z|, held as a DATA_W-bit unsigned value so |−2^(DATA_W−1)| is representable. Load divider: numerator abs_z << FRAC_W, divisor one + abs_z. → DIVIDE.
- DIVIDE: restoring division, one quotient bit per cycle, MSB first, FRAC_W cycles. Result q = floor(abs_z·2^FRAC_W / (one+abs_z)), so 0 ≤ q < one. → DONE.
- DONE: out_val ← (one + q) >> 1 if sign=0, else (one − q) >> 1. out_valid=1. On out_ready → IDLE.
- out_val and out_valid are registered. out_val holds its last result after the handshake until the next DONE.
- Reset: all state cleared asynchronously. in_ready=0, out_valid=0, out_val=0, busy=0, state IDLE. Reset mid-evaluation discards it; no partial output.

## Timing
- Start accepted at cycle s → in_ready high at s+1.
- Last pair accepted at cycle t → NORM at t+1, DIVIDE at t+2 … t+1+FRAC_W, out_valid high at t+2+FRAC_W.
- Minimum start-to-result latency is 1 + N_INPUTS + 1 + FRAC_W cycles with no stalls; default 22.
- out_ready may be high before out_valid. The earliest next start is the cycle after the output handshake.
- out_val is stable while out_valid=1 and out_ready=0.

## Configuration
- NEURON_SAT_EN defined: z reduction in NORM saturates to [−2^(DATA_W−1), 2^(DATA_W−1)−1] when acc >>> FRAC_W exceeds DATA_W.
- Not defined: z reduction truncates to the low DATA_W bits (wraps). Costs no comparator logic.

## Structure
- Package neuron_pkg: state enum type, localparam ONE = 1 << FRAC_W helper function, $clog2-based width helpers shared with other layer blocks.
- One sub-module: neuron_div_seq, the iterative unsigned restoring divider. Parametrised width, with start/done handshake and a fixed FRAC_W-cycle latency.

## Test plan
- Defaults, bias=0, all pairs x=0 → z=0, out_val=32768, out_valid at cycle 22 after start.
- bias=0, pair0 x=65536, w=65536, other pairs x=0 → z=65536, q=32768, out_val=49152.
- bias=−65536, all x=0 → out_val=16384. bias=196608 (z=3.0) → q=49152, out_val=57344.
- in_valid toggled every other cycle, out_ready held low 5 cycles → result unchanged, out_val stable, no pair lost or duplicated.
- rst_n pulsed low mid-DIVIDE → out_valid=0, busy=0 immediately. The next start with the z=65536 stimulus yields 49152.
- With NEURON_SAT_EN, pairs x=w=0x7FFF0000 ×4 → z saturates to 0x7FFFFFFF, out_val=65535. Without the macro, the wrapped z is checked against a reference model.
